perf_readout: RTL
=================

// Module: perf_readout
// PURPOSE
//  Reader side of the perf_counter bank's read_src/clear/read_data interface.
//  Exposes the counters to software as an MMIO window on the data-memory bus.
//  A CTRL write triggers a hardware sweep: all NUM_CNT counters are copied into shadow registers,
//  one per cycle, optionally with clear-on-read. Software then reads a coherent snapshot at leisure.
// PARAMETERS
//  NUM_CNT    11              counters swept (indices 0..NUM_CNT-1); max 32
//  BASE_ADDR  32'hFFFF_FF00   window base, 256-byte aligned; window = BASE_ADDR..BASE_ADDR+0xFF
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  mem_read     in   1   bus read request, held until mem_resp
//  mem_write    in   1   bus write request, held until mem_resp
//  mem_address  in   32  bus byte address; bits[1:0] ignored
//  mem_wdata    in   32  write data
//  mem_sel      out  1   comb: mem_address inside window; bus mux routes mem_rdata/mem_resp
//  mem_rdata    out  32  read data, valid while mem_resp=1
//  mem_resp     out  1   one-cycle response pulse
//  read_src     out  5   counter index to perf_counter, registered
//  clear        out  1   clear strobe to perf_counter, registered
//  read_data    in   32  comb data from perf_counter for read_src
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   - 0x00+4*i, i<NUM_CNT: SHADOW[i], read-only.
//   - 0x80: CTRL, write-only. bit0 = SNAP, bit1 = CLR.
//   - 0x84: STATUS, read-only. [0] = busy (always 0 when seen by the single master); [15:8] = snap_seq.
//   - Other in-window offsets: reads return 0; writes are dropped but still get mem_resp.
//  Reset (async, rst_n=0):
//   - FSM to IDLE; read_src=0, clear=0, mem_resp=0, mem_rdata=0.
//   - SHADOW[*]=0, snap_seq=0.
//   - Counters already cleared mid-sweep stay cleared; perf_counter has no reset.
//  FSM IDLE:
//   - Request with mem_sel=1, not a CTRL write with SNAP=1: capture rdata, go to RESP.
//     Latency is 1 cycle from request to mem_resp.
//   - CTRL write with SNAP=1: latch CLR; idx=0; read_src<=0; clear<=CLR; go to SWEEP.
//   - mem_read & mem_write both high: treated as a write.
//  FSM SWEEP (NUM_CNT cycles):
//   - Each cycle: SHADOW[idx] <= read_data, the pre-clear value.
//     The counter zeroes at the same edge because clear=CLR and read_src=idx.
//   - Then idx++ and read_src <= idx+1.
//   - After idx=NUM_CNT-1: clear<=0, read_src<=0, snap_seq <= snap_seq+1 (8-bit wrap), go to RESP.
//   - Write latency = NUM_CNT+1 cycles.
//  FSM RESP:
//   - mem_resp=1 for exactly one cycle; the request is ignored this cycle; then go to IDLE.
//   - The requester must drop or change its request on the next cycle.
//  Increment vs clear collision:
//   - A counter event in the same cycle it is cleared is lost; clear wins.
//   - SHADOW holds the value before that event.
//  Requests with mem_sel=0: no response, no state change.
// STRUCTURE
//  Package perf_pkg:
//   - perf_cnt_e enum: L1I_HIT=0, L1I_MISS, L1D_HIT, L1D_MISS, L2_HIT, L2_MISS, BRANCH,
//     MISPREDICT, STALL, RESET, JAL_RESET=10.
//   - NUM_PERF_CNT; CTRL_OFS=8'h80; STATUS_OFS=8'h84; CTRL bit positions.
//  Sub-module perf_shadow_regfile:
//   - NUM_CNT x 32 registers; one write port (idx, data, we); one comb read port.
//  Top level holds the FSM, address decode and bus response.
// TESTING
//  1. Counters 0..10 preloaded to 100+i; write CTRL=1 (SNAP, no CLR)
//     -> mem_resp at cycle 12; SHADOW[i]=100+i; counters unchanged; STATUS[15:8]=1.
//  2. Write CTRL=3 (SNAP+CLR) -> clear=1 on cycles 1..11 with read_src=0..10;
//     SHADOW[i]=pre-clear values; all counters read 0 afterwards.
//  3. Stall event during SNAP+CLR at the cycle read_src=8 -> SHADOW[8]=old value; counter 8 = 0 after.
//  4. Read BASE+0x30 (i=12, unmapped) -> rdata 0 after 1 cycle.
//     Write to BASE+0x90 -> mem_resp, no state change.
//     Address outside window -> mem_sel=0, no mem_resp.
//  5. Request held through RESP -> exactly one mem_resp pulse per request.
//     256 snapshots -> snap_seq wraps to 0.
//  6. rst_n low at sweep idx=5 with CLR -> outputs and SHADOW = 0 immediately.
//     Counters 0..4 stay 0, 5..10 keep their values; next request is served normally.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and register-map constants for the perf counter readout window.
package perf_pkg;

    typedef enum logic [4:0] {
        L1I_HIT    = 5'd0,
        L1I_MISS   = 5'd1,
        L1D_HIT    = 5'd2,
        L1D_MISS   = 5'd3,
        L2_HIT     = 5'd4,
        L2_MISS    = 5'd5,
        BRANCH     = 5'd6,
        MISPREDICT = 5'd7,
        STALL      = 5'd8,
        RESET      = 5'd9,
        JAL_RESET  = 5'd10
    } perf_cnt_e;

    localparam int NUM_PERF_CNT = 11;

    localparam logic [7:0] CTRL_OFS   = 8'h80;
    localparam logic [7:0] STATUS_OFS = 8'h84;

    localparam int CTRL_SNAP_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_RESP
    } rd_state_e;

endpackage

// File: rtl/perf_shadow_regfile.sv
// Snapshot storage: one write port filled by the sweep, one combinational read port for the bus.
module perf_shadow_regfile #(
    parameter int NUM_CNT = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  widx_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  ridx_i,
    output logic [31:0] rdata_o
);

    localparam int         IW        = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
    localparam logic [5:0] NUM_CNT_W = 6'(NUM_CNT);

    logic [31:0] regsQ [NUM_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                regsQ[i] <= '0;
            end
        end else if (we_i && ({1'b0, widx_i} < NUM_CNT_W)) begin
            regsQ[widx_i[IW-1:0]] <= wdata_i;
        end
    end

    // Indices past the last counter read as zero so unmapped shadow slots are harmless.
    always_comb begin
        rdata_o = '0;
        if ({1'b0, ridx_i} < NUM_CNT_W) begin
            rdata_o = regsQ[ridx_i[IW-1:0]];
        end
    end

endmodule

// File: rtl/perf_readout.sv
// MMIO window over the perf counter bank: a CTRL write sweeps every counter into shadow
// registers (optionally clearing them), and software reads the coherent snapshot afterwards.
module perf_readout
    import perf_pkg::*;
#(
    parameter int          NUM_CNT   = NUM_PERF_CNT,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic [4:0]  read_src,
    output logic        clear,
    input  logic [31:0] read_data
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_CNT - 1);

    rd_state_e   stateQ, stateD;
    logic [4:0]  readSrcQ, readSrcD;
    logic        clearQ, clearD;
    logic [7:0]  snapSeqQ, snapSeqD;
    logic [31:0] rdataQ, rdataD;

    logic        req;
    logic        isCtrl;
    logic        isStatus;
    logic        startSweep;
    logic        shadowWe;
    logic [31:0] shadowRdata;
    logic [31:0] statusWord;
    logic        unusedBits;

    assign unusedBits = ^{mem_address[1:0], mem_wdata[31:2]};

    assign mem_sel    = (mem_address[31:8] == BASE_ADDR[31:8]);
    assign req        = mem_sel && (mem_read || mem_write);
    assign isCtrl     = (mem_address[7:2] == CTRL_OFS[7:2]);
    assign isStatus   = (mem_address[7:2] == STATUS_OFS[7:2]);
    assign startSweep = req && mem_write && isCtrl && mem_wdata[CTRL_SNAP_BIT];
    assign statusWord = {16'h0, snapSeqQ, 7'h0, (stateQ == ST_SWEEP)};

    perf_shadow_regfile #(
        .NUM_CNT (NUM_CNT)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (shadowWe),
        .widx_i  (readSrcQ),
        .wdata_i (read_data),
        .ridx_i  (mem_address[6:2]),
        .rdata_o (shadowRdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= ST_IDLE;
            readSrcQ <= '0;
            clearQ   <= 1'b0;
            snapSeqQ <= '0;
            rdataQ   <= '0;
        end else begin
            stateQ   <= stateD;
            readSrcQ <= readSrcD;
            clearQ   <= clearD;
            snapSeqQ <= snapSeqD;
            rdataQ   <= rdataD;
        end
    end

    // read_src doubles as the sweep index, so the counter bank and the shadow write agree by construction.
    always_comb begin
        stateD   = stateQ;
        readSrcD = readSrcQ;
        clearD   = clearQ;
        snapSeqD = snapSeqQ;
        rdataD   = rdataQ;
        shadowWe = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                if (startSweep) begin
                    readSrcD = '0;
                    clearD   = mem_wdata[CTRL_CLR_BIT];
                    stateD   = ST_SWEEP;
                end else if (req) begin
                    stateD = ST_RESP;
                    if (mem_write) begin
                        rdataD = '0;
                    end else if (!mem_address[7]) begin
                        rdataD = shadowRdata;
                    end else if (isStatus) begin
                        rdataD = statusWord;
                    end else begin
                        rdataD = '0;
                    end
                end
            end
            ST_SWEEP: begin
                shadowWe = 1'b1;
                if (readSrcQ == LAST_IDX) begin
                    readSrcD = '0;
                    clearD   = 1'b0;
                    snapSeqD = snapSeqQ + 8'd1;
                    rdataD   = '0;
                    stateD   = ST_RESP;
                end else begin
                    readSrcD = readSrcQ + 5'd1;
                end
            end
            ST_RESP: begin
                rdataD = '0;
                stateD = ST_IDLE;
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    assign mem_resp  = (stateQ == ST_RESP);
    assign mem_rdata = rdataQ;
    assign read_src  = readSrcQ;
    assign clear     = clearQ;

endmodule
